// File: rtl/conv3x3_seq.sv
// conv3x3_seq: sequences a combinational 3x3 MAC across a whole feature map
// (stride 1, no padding). For each output pixel it fetches the 3x3 input
// window from a synchronous feature RAM, holds it on mac_win with the kernel,
// bias and relu setting latched at start, captures the MAC result and writes
// it to the output RAM. Each output takes 12 cycles: 9 fetch, 1 last-capture,
// 1 calc, 1 write.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle run request (accepted only in idle)
//   kernel, bias, relu_en    MAC settings, latched on an accepted start
//   busy, done               run in progress / one-cycle completion pulse
//   rd_en, rd_addr, rd_data  feature RAM port (data one cycle after rd_en)
//   mac_win, mac_kern,
//   mac_bias, mac_relu       operands to the MAC (element 0 in the MSBs)
//   mac_dout                 combinational MAC result
//   wr_en, wr_addr, wr_data  output RAM write port
module conv3x3_seq #(
  parameter int unsigned IMG_W     = 8,
  parameter int unsigned IMG_H     = 8,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [9*DATA_SIZE-1:0] kernel,
  input  logic [DATA_SIZE-1:0]   bias,
  input  logic                   relu_en,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [DATA_SIZE-1:0]   rd_data,
  output logic [9*DATA_SIZE-1:0] mac_win,
  output logic [9*DATA_SIZE-1:0] mac_kern,
  output logic [DATA_SIZE-1:0]   mac_bias,
  output logic                   mac_relu,
  input  logic [DATA_SIZE-1:0]   mac_dout,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_SIZE-1:0]   wr_data
);

  localparam logic [ADDR_W-1:0] ImgW    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OutW    = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ColLast = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] RowLast = ADDR_W'(IMG_H - 3);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLast,
    StCalc,
    StWrite,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]    row_q, col_q;
  logic [3:0]           k_q;
  logic [DATA_SIZE-1:0] win_q [9];

  logic                 col_wrap;
  logic                 last_out;
  logic [ADDR_W-1:0]    k_row, k_col;
  logic [ADDR_W-1:0]    fetch_addr;

  assign col_wrap = (col_q == ColLast);
  assign last_out = col_wrap && (row_q == RowLast);

  // Window tap k maps to row offset k/3 and column offset k%3.
  assign k_row      = ADDR_W'(k_q / 4'd3);
  assign k_col      = ADDR_W'(k_q % 4'd3);
  assign fetch_addr = (row_q + k_row) * ImgW + col_q + k_col;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (k_q == 4'd8) state_d = StLast;
      StLast:  state_d = StCalc;
      StCalc:  state_d = StWrite;
      StWrite: state_d = last_out ? StDone : StFetch;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode.
  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    rd_en   = (state_q == StFetch);
    wr_en   = (state_q == StWrite);
    rd_addr = rd_en ? fetch_addr : '0;
  end

  // Datapath: counters, window slots, latched MAC settings, write result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      mac_kern <= '0;
      mac_bias <= '0;
      mac_relu <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            mac_kern <= kernel;
            mac_bias <= bias;
            mac_relu <= relu_en;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
          end
        end
        StFetch: begin
          // Data from the read issued last cycle belongs to slot k-1.
          if (k_q != 4'd0) begin
            win_q[k_q - 4'd1] <= rd_data;
          end
          k_q <= k_q + 4'd1;
        end
        StLast: begin
          win_q[8] <= rd_data;
          k_q      <= '0;
        end
        StCalc: begin
          wr_data <= mac_dout;
          wr_addr <= row_q * OutW + col_q;
        end
        StWrite: begin
          if (col_wrap) begin
            col_q <= '0;
            row_q <= row_q + ADDR_W'(1);
          end else begin
            col_q <= col_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Pack the window slots, slot 0 in the MSBs.
  always_comb begin
    mac_win = '0;
    for (int i = 0; i < 9; i++) begin
      mac_win[DATA_SIZE*(8-i) +: DATA_SIZE] = win_q[i];
    end
  end

endmodule

// File: doc/conv3x3_seq.md
Name: conv3x3_seq

Overview:
- Sequencer that drives the combinational 3x3 sign-magnitude multiply-accumulate unit (8-bit elements, bias, optional ReLU) across a whole feature map.
- Stride 1, no padding.
- Fetches each 3x3 input window from a synchronous feature-map RAM, presents the window with a latched kernel/bias/relu setting to the MAC, and writes each result to an output RAM.
- Sits between the layer controller (start/done) and the memories, one instance per conv engine.

Parameters:
- IMG_W, 8: input map width in pixels; must be >= 3.
- IMG_H, 8: input map height in pixels; must be >= 3.
- DATA_SIZE, 8: element width, sign-magnitude.
- ADDR_W, 16: read and write address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to process a map; ignored unless the block is in IDLE.
- kernel  in  9*DATA_SIZE  3x3 kernel; element i (i = r*3+c) occupies bits [DATA_SIZE*(9-i)-1 -: DATA_SIZE], element 0 in the MSBs; latched on accepted start.
- bias  in  DATA_SIZE  latched on accepted start.
- relu_en  in  1  latched on accepted start.
- busy  out  1  high while a map is in progress.
- done  out  1  one-cycle pulse when the last output has been written.
- rd_en  out  1  feature RAM read strobe.
- rd_addr  out  ADDR_W  feature RAM read address.
- rd_data  in  DATA_SIZE  read data, valid exactly 1 cycle after rd_en.
- mac_win  out  9*DATA_SIZE  registered window to the MAC matrix1; same packing as kernel.
- mac_kern  out  9*DATA_SIZE  latched kernel to the MAC matrix2.
- mac_bias  out  DATA_SIZE  latched bias.
- mac_relu  out  1  latched relu_en.
- mac_dout  in  DATA_SIZE  MAC result, combinational from the mac_* outputs.
- wr_en  out  1  output RAM write strobe.
- wr_addr  out  ADDR_W  output RAM write address.
- wr_data  out  DATA_SIZE  output RAM write data.

Behaviour:
- Reset (asynchronous, any state, including mid-map):
  - state = IDLE; row, col and k counters = 0.
  - All outputs 0: busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, mac_win, mac_kern, mac_bias, mac_relu.
  - No partial write is issued after reset deasserts.
- Output map is (IMG_W-2) x (IMG_H-2). Outputs are produced in raster order: col fastest, then row.
- FSM states: IDLE, FETCH, LAST, CALC, WRITE, DONE.
- IDLE:
  - On start: latch kernel, bias and relu_en into mac_kern, mac_bias and mac_relu; clear row and col; go to FETCH.
  - busy rises on the cycle after start.
  - kernel/bias/relu_en changes during busy have no effect.
- FETCH (9 cycles, k = 0..8):
  - rd_en = 1.
  - rd_addr = (row + k/3)*IMG_W + col + k%3.
  - Each cycle, rd_data from the previous cycle's read is written into mac_win slot k-1 (for k >= 1).
  - After k = 8, go to LAST.
- LAST: rd_en = 0; capture rd_data into slot 8; go to CALC.
- CALC:
  - mac_win holds the complete window and is stable.
  - Register wr_data <= mac_dout and wr_addr <= row*(IMG_W-2) + col.
  - Go to WRITE.
- WRITE:
  - wr_en = 1 for exactly this cycle.
  - Advance counters: col+1; if col = IMG_W-3, then col = 0 and row+1.
  - If this was the last output (row = IMG_H-3 and col = IMG_W-3), go to DONE; else go to FETCH.
- DONE: done = 1 and busy = 1 for this cycle only; next state IDLE (busy = 0).
- Cycle budget:
  - 12 cycles per output (9 FETCH + LAST + CALC + WRITE).
  - With start sampled at cycle 0, the n-th write (n from 1) is at cycle 12n and done is at cycle 12N+1, where N is the output count.
- start is ignored while in DONE.
- A start pulse in the cycle immediately after done (i.e. while back in IDLE) is accepted normally.
- mac_win keeps the last window after completion; it is cleared only by reset.
- Address arithmetic is unsigned, truncated to ADDR_W. Integration guarantees IMG_W*IMG_H <= 2^ADDR_W; the block does not check it.

Test Plan:
- Reset mid-FETCH:
  - Stimulus: assert rst at cycle 5 after start.
  - Required: all outputs 0 immediately (asynchronously).
  - Required after release: no wr_en until a new start; the new start yields 12 cycles to the first write.
- 4x4 map, pixel at address a holds value a (0..15), kernel all 8'h01, bias 0:
  - Expect 4 writes at cycles 12/24/36/48 to wr_addr 0, 1, 2, 3.
  - Expect done at cycle 49.
  - First mac_win = {00,01,02,04,05,06,08,09,0A}; last mac_win = {05,06,07,09,0A,0B,0D,0E,0F}.
- MAC stub returning 8'hA5 when relu_en=1 and 8'h3C otherwise:
  - Stimulus: start with relu_en=1, then toggle the relu_en input to 0 during the run.
  - Required: every wr_data = 8'hA5, and mac_relu stays 1 for the whole run.
- Start while busy:
  - Stimulus: pulse start at cycles 3 and 30 of a 4x4 run.
  - Required: still exactly 4 writes and one done; the latched kernel is unchanged.
- 3x3 map (single output), kernel = 72'h81_02_83_04_85_06_87_08_89, bias = 8'h80:
  - Required: one write at cycle 12 to wr_addr 0; done at cycle 13.
  - Required: mac_kern and mac_bias equal the start-time values bit-exactly.
- Back-to-back runs:
  - Stimulus: start in the cycle after done.
  - Required: accepted; the second run has identical timing, with counters restarted from row 0, col 0.
